// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU responder slice.
package alu_pkg;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;
endpackage

// File: rtl/alu_responder_if.sv
// Request and response valid/ready channels of the ALU responder.
interface alu_responder_if #(parameter int WIDTH = alu_pkg::WIDTH);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_opcode;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_opcode, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_opcode, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_cout
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: {cout,out} for add, subtract (borrow), and, pass-A.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       opcode,
  output logic [WIDTH:0]   res
);
  always_comb begin
    res = '0;
    case (opcode)
      OP_ADD:  res = {1'b0, a} + {1'b0, b};
      OP_SUB:  res = {1'b0, a} - {1'b0, b};
      OP_AND:  res = {1'b0, a & b};
      default: res = {1'b0, a};
    endcase
  end
endmodule

// File: rtl/alu_responder.sv
// Registered ALU endpoint with a 2-entry in-order result queue.
//   state     | meaning
//   OCC_EMPTY | no result held, rsp_valid low
//   OCC_ONE   | one result held, can accept freely
//   OCC_FULL  | two results held, accept only alongside a pop
module alu_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = alu_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  alu_responder_if.slave     bus,
  output logic [CNT_W-1:0]   op_count
);
  occ_t             occ_q, occ_d;
  logic [WIDTH:0]   mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [WIDTH:0]   alu_res;
  logic             push, pop;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (bus.req_a),
    .b      (bus.req_b),
    .opcode (bus.req_opcode),
    .res    (alu_res)
  );

  // Full queue still accepts when the head leaves on the same edge.
  assign bus.req_ready = enable && ((occ_q != OCC_FULL) || bus.rsp_ready);
  assign bus.rsp_valid = (occ_q != OCC_EMPTY);
  assign {bus.rsp_cout, bus.rsp_out} = mem_q[rd_ptr_q];

  assign push = bus.req_valid && bus.req_ready;
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   occ_d = (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= OCC_EMPTY;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      op_count <= '0;
    end else begin
      occ_q <= occ_d;
      if (push) begin
        mem_q[wr_ptr_q] <= alu_res;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (op_count != '1) op_count <= op_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_responder.sv
// Directed plus randomized bench for alu_responder against a queue-based reference model.
module tb_alu_responder;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] op_count;

  alu_responder_if #(.WIDTH(4)) bus ();

  alu_responder #(.WIDTH(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] model_q [$];
  int         model_cnt = 0;
  int         base_cnt;

  function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    int s;
    case (op)
      2'b00: begin s = int'(a) + int'(b); return 5'(s); end
      2'b01: begin s = int'(a) - int'(b); return {s < 0, 4'(s + 16)}; end
      2'b10: return {1'b0, a & b};
      default: return {1'b0, a};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, input logic rr, input logic en);
    bus.req_valid  = v;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_opcode = op;
    bus.rsp_ready  = rr;
    enable         = en;
  endtask

  // Check outputs against the model, then advance the model across one rising edge.
  task automatic step(input string tag);
    logic       exp_ready, do_push, do_pop;
    logic [4:0] res;
    #1;
    exp_ready = enable && (model_q.size() < 2 || bus.rsp_ready);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(exp_ready));
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      chk({tag, ".rsp_out"}, 32'(bus.rsp_out), 32'(model_q[0][3:0]));
      chk({tag, ".rsp_cout"}, 32'(bus.rsp_cout), 32'(model_q[0][4]));
    end
    chk({tag, ".op_count"}, 32'(op_count), 32'(model_cnt));
    do_push = bus.req_valid && exp_ready;
    do_pop  = (model_q.size() != 0) && bus.rsp_ready;
    res     = ref_alu(bus.req_a, bus.req_b, bus.req_opcode);
    @(posedge clk);
    if (do_pop) begin
      void'(model_q.pop_front());
      if (model_cnt < 255) model_cnt++;
    end
    if (do_push) model_q.push_back(res);
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 4'h0, 4'h0, OP_ADD, 1'b0, 1'b0);
    #2;
    chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset.rsp_out", 32'(bus.rsp_out), 32'd0);
    chk("reset.rsp_cout", 32'(bus.rsp_cout), 32'd0);
    chk("reset.op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // add overflow
    drive(1'b1, 4'hF, 4'h1, OP_ADD, 1'b1, 1'b1);
    step("add_ovf");
    chk("add_ovf.valid_next", 32'(bus.rsp_valid), 32'd1);
    chk("add_ovf.out_next", 32'(bus.rsp_out), 32'd0);
    chk("add_ovf.cout_next", 32'(bus.rsp_cout), 32'd1);
    drive(1'b0, 4'h0, 4'h0, OP_ADD, 1'b1, 1'b1);
    step("add_ovf_drain");

    // directed op patterns, back to back
    drive(1'b1, 4'h3, 4'h5, OP_SUB, 1'b1, 1'b1);  step("sub_borrow");
    chk("sub_borrow.out", 32'(bus.rsp_out), 32'hE);
    chk("sub_borrow.cout", 32'(bus.rsp_cout), 32'd1);
    drive(1'b1, 4'h5, 4'h3, OP_SUB, 1'b1, 1'b1);  step("sub_noborrow");
    drive(1'b1, 4'hC, 4'hA, OP_AND, 1'b1, 1'b1);  step("and");
    drive(1'b1, 4'h7, 4'h9, OP_PASS, 1'b1, 1'b1); step("pass");
    drive(1'b0, 4'h0, 4'h0, OP_ADD, 1'b1, 1'b1);  step("ops_drain");
    step("ops_idle");

    // backpressure: third request waits, then enters with the first pop
    drive(1'b1, 4'h9, 4'h8, OP_ADD, 1'b0, 1'b1);  step("bp_req1");
    drive(1'b1, 4'h2, 4'h6, OP_SUB, 1'b0, 1'b1);  step("bp_req2");
    drive(1'b1, 4'hB, 4'h7, OP_AND, 1'b0, 1'b1);  step("bp_req3_blocked");
    step("bp_stall");
    drive(1'b1, 4'hB, 4'h7, OP_AND, 1'b1, 1'b1);  step("bp_req3_with_pop");
    drive(1'b0, 4'h0, 4'h0, OP_ADD, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("bp_drain");

    // enable low with two queued
    drive(1'b1, 4'h4, 4'h4, OP_ADD, 1'b0, 1'b1);  step("en_fill1");
    drive(1'b1, 4'h1, 4'h2, OP_SUB, 1'b0, 1'b1);  step("en_fill2");
    drive(1'b1, 4'hF, 4'hF, OP_PASS, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step("en_off_stall");
    drive(1'b1, 4'hF, 4'hF, OP_PASS, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("en_off_drain");

    // async reset with a full queue
    drive(1'b1, 4'hA, 4'h3, OP_ADD, 1'b0, 1'b1);  step("rst_fill1");
    drive(1'b1, 4'h6, 4'h6, OP_AND, 1'b0, 1'b1);  step("rst_fill2");
    #2;
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 4'h0, OP_ADD, 1'b0, 1'b1);
    #1;
    chk("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid.rsp_out", 32'(bus.rsp_out), 32'd0);
    chk("rst_mid.rsp_cout", 32'(bus.rsp_cout), 32'd0);
    chk("rst_mid.op_count", 32'(op_count), 32'd0);
    model_q.delete();
    model_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 4'h0, OP_ADD, 1'b1, 1'b1);  step("post_rst_idle");
    drive(1'b1, 4'h8, 4'h9, OP_ADD, 1'b1, 1'b1);  step("post_rst_req");
    drive(1'b0, 4'h0, 4'h0, OP_ADD, 1'b1, 1'b1);  step("post_rst_rsp");

    // streaming, one op per cycle
    base_cnt = model_cnt;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b1, 1'b1);
      step("stream");
    end
    drive(1'b0, 4'h0, 4'h0, OP_ADD, 1'b1, 1'b1);  step("stream_tail");
    chk("stream.op_count", 32'(op_count), 32'(base_cnt + 20));
    chk("stream.empty", 32'(bus.rsp_valid), 32'd0);

    // random traffic with backpressure and enable toggling
    for (int i = 0; i < 120; i++) begin
      drive(1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), ($urandom_range(0, 3) != 0));
      step("random");
    end

    // op_count saturation
    for (int i = 0; i < 270; i++) begin
      drive(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b1, 1'b1);
      step("saturate");
    end
    chk("saturate.op_count", 32'(op_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
